// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART definitions: data width, line levels and the feeder state encoding.
package uart_tx_feeder_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned FEEDER_DEPTH = 16;

  localparam logic IDLE_VAL  = 1'b1;
  localparam logic START_VAL = 1'b0;
  localparam logic STOP_VAL  = 1'b1;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_START = 2'd1,
    F_WAIT  = 2'd2
  } t_feeder_state;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Circular FIFO with occupancy count; head is visible on o_pop_data, no fall-through.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_pop_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full     = (r_level == LVL_W'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rd_ptr];

  // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to uart_tx one frame at a time,
// holding tx_data stable until the frame's stop bit.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = FEEDER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  t_feeder_state     r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;

  assign wr_ready = !full;
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = (r_state == F_IDLE) && !empty && !tx_busy;
  assign tx_start = (r_state == F_START);
  assign tx_data  = r_tx_data;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_level     (level),
    .o_empty     (empty),
    .o_full      (full)
  );

  // One frame in flight at a time; tx_done only matters while waiting on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= F_IDLE;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_state   <= F_START;
          end
        end
        F_START: r_state <= F_WAIT;
        F_WAIT: begin
          if (tx_done) begin
            r_state <= F_IDLE;
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with a behavioural uart_tx and a queue-based reference model.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  typedef logic [7:0] u8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       force_busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_feeder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .level(level), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Behavioural uart_tx: phase 1 settle, 2 start bit, 3..10 data LSB first, 11 stop + done.
  int u_p = 0;
  always @(posedge clk) begin
    if (rst) u_p <= 0;
    else if (u_p != 0) u_p <= (u_p == 11) ? 0 : u_p + 1;
    else if (tx_start) u_p <= 1;
  end
  assign tx_busy = (u_p != 0) || force_busy;
  assign tx_done = (u_p == 11);
  always_comb begin
    tx = 1'b1;
    if (u_p == 2) tx = 1'b0;
    else if (u_p >= 3 && u_p <= 10) tx = tx_data[3'(u_p - 3)];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue plus "frame outstanding" flag, advanced at each edge.
  u8  mq[$];
  u8  sent_q[$];
  u8  m_data = 8'h00;
  bit m_start = 1'b0;
  bit m_frame = 1'b0;
  always @(posedge clk) begin
    bit push_now;
    bit pop_now;
    cyc++;
    if (rst) begin
      mq.delete();
      sent_q.delete();
      m_data  = 8'h00;
      m_start = 1'b0;
      m_frame = 1'b0;
    end else begin
      push_now = wr_valid && (mq.size() < DEPTH);
      pop_now  = !m_frame && (mq.size() > 0) && !tx_busy;
      if (m_frame && !m_start && tx_done) m_frame = 1'b0;
      if (pop_now) begin
        m_data = mq.pop_front();
        sent_q.push_back(m_data);
        m_frame = 1'b1;
      end
      if (push_now) mq.push_back(wr_data);
      m_start = pop_now;
    end
  end

  // Compare process plus line decoder.
  u8  dec_sh;
  u8  last_dec;
  int n_dec = 0;
  logic last_bits [10];
  int start_cyc[$];
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("level", int'(level), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("wr_ready", int'(wr_ready), int'(mq.size() != DEPTH));
      chk("tx_start", int'(tx_start), int'(m_start));
      chk("tx_data", int'(tx_data), int'(m_data));
      if (tx_start) start_cyc.push_back(cyc);
      if (u_p == 2) begin
        chk("start_bit", int'(tx), 0);
        last_bits[0] = tx;
      end else if (u_p >= 3 && u_p <= 10) begin
        dec_sh[3'(u_p - 3)] = tx;
        last_bits[u_p - 2] = tx;
      end else if (u_p == 11) begin
        chk("stop_bit", int'(tx), 1);
        last_bits[9] = tx;
        if (sent_q.size() == 0) chk("dec_unexpected", 1, 0);
        else chk("dec_byte", int'(dec_sh), int'(sent_q.pop_front()));
        last_dec = dec_sh;
        n_dec++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((mq.size() != 0 || m_frame || u_p != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n >= bound), 0);
  endtask

  task automatic wait_dec(input int target, input int bound);
    int n = 0;
    while (n_dec < target && n < bound) begin
      tick();
      n++;
    end
    chk("decode_timeout", int'(n >= bound), 0);
  endtask

  initial begin
    int t0;
    int n;
    logic exp_bits [10];
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; force_busy = 1'b0;
    repeat (3) tick();
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx", int'(tx), 1);
    rst = 1'b0;
    tick();

    // 1: single byte latency and bit pattern.
    start_cyc.delete();
    t0 = cyc;
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wait_dec(1, 40);
    chk("t1_start_count", start_cyc.size(), 1);
    if (start_cyc.size() > 0) chk("t1_latency", start_cyc[0] - t0, 2);
    for (int i = 0; i < 10; i++) chk("t1_bit", int'(last_bits[i]), int'(exp_bits[i]));
    chk("t1_byte", int'(last_dec), 8'hA5);
    wait_idle(40);
    chk("t1_level", int'(level), 0);

    // 2: sixteen back-to-back pushes; pops at cycles 1 and 14 overlap the burst.
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    chk("t2_level", int'(level), 14);
    wait_idle(400);
    chk("t2_count", n_dec, 17);

    // 3: continuous producer, 40 bytes; one frame per 13 clocks.
    start_cyc.delete();
    wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'(8'h40 + i);
      n = 0;
      while (!wr_ready && n < 50) begin
        tick();
        n++;
      end
      chk("t3_ready_timeout", int'(n >= 50), 0);
      tick();
    end
    wr_valid = 1'b0;
    wait_idle(800);
    chk("t3_starts", start_cyc.size(), 40);
    for (int k = 1; k < start_cyc.size(); k++) chk("t3_period", start_cyc[k] - start_cyc[k-1], 13);

    // Random traffic with sporadic foreign-master busy.
    for (int i = 0; i < 300; i++) begin
      wr_valid   = ($urandom % 3) == 0;
      wr_data    = 8'($urandom);
      force_busy = ($urandom % 8) == 0;
      tick();
    end
    wr_valid = 1'b0; force_busy = 1'b0;
    wait_idle(800);

    // 4: uart held busy by someone else; no pop until release.
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hC0 + i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    start_cyc.delete();
    repeat (10) tick();
    chk("t4_level_held", int'(level), 3);
    chk("t4_no_start", start_cyc.size(), 0);
    t0 = cyc;
    force_busy = 1'b0;
    repeat (3) tick();
    chk("t4_start_count", start_cyc.size(), 1);
    if (start_cyc.size() > 0) chk("t4_release_latency", start_cyc[0] - t0, 1);
    wait_idle(200);

    // 5: reset in the middle of a frame with five bytes queued.
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h90 + i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    chk("t5_level_pre", int'(level), 5);
    chk("t5_mid_frame", int'(u_p >= 3 && u_p <= 10), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_level", int'(level), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_tx_start", int'(tx_start), 0);
    chk("t5_tx", int'(tx), 1);
    n = n_dec;
    wr_data = 8'h3C; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wait_dec(n + 1, 40);
    chk("t5_fresh_byte", int'(last_dec), 8'h3C);
    wait_idle(40);

    // 6: full FIFO, pop and blocked push in the same cycle.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'hE0 + i); wr_valid = 1'b1;
      tick();
    end
    chk("t6_full", int'(full), 1);
    chk("t6_wr_ready", int'(wr_ready), 0);
    wr_data = 8'h77; force_busy = 1'b0;
    tick();
    chk("t6_level_after_pop", int'(level), 15);
    chk("t6_ready_again", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    chk("t6_level_after_push", int'(level), 16);
    wait_idle(600);
    chk("t6_last_byte", int'(last_dec), 8'h77);
    chk("final_sent_empty", sent_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
